dsi_packet_assembler: RTL

// Builds MIPI DSI packets (short and long) and streams them as 32-bit words into
// the lanes controller over the iface_* word handshake. Long packets get the
// 4-byte header with ECC, the payload, and the CRC-16.
// It sits directly upstream of dsi_lanes_controller. Everything runs in clk_sys.

---
 rtl/dsi_packet_assembler.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/dsi_packet_assembler.sv
// DSI packet assembler: builds short/long packets (header+ECC, payload, CRC-16)
// and streams them as 32-bit words through a single registered output slot.
module dsi_packet_assembler #(
  parameter bit CRC_ENABLE = 1'b1
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        pkt_rqst,
  input  logic        pkt_long,
  input  logic [7:0]  pkt_data_id,
  input  logic [15:0] pkt_word_count,
  output logic        pkt_busy,
  output logic        pkt_done,
  input  logic [31:0] pld_data,
  input  logic        pld_valid,
  output logic        pld_ready,
  output logic [31:0] iface_write_data,
  output logic [3:0]  iface_write_strb,
  output logic        iface_write_rqst,
  output logic        iface_last_word,
  input  logic        iface_data_rqst
);

  // S_LAST holds the final word of the packet until the controller takes it
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PLD, S_CRC, S_LAST} state_t;

  state_t      state_q, state_d;
  logic [7:0]  di_q, di_d;
  logic [15:0] wc_q, wc_d;
  logic        long_q, long_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] crc_q, crc_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  strb_q, strb_d;
  logic        rqst_q, rqst_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [5:0] dsi_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  logic        slot_free;
  logic [2:0]  k;
  logic [15:0] crc_b1, crc_b2, crc_b3, crc_b4, crc_upd, crc_tx, crc_hold;
  logic [5:0]  ecc;

  assign slot_free = !rqst_q || iface_data_rqst;
  assign k         = (rem_q >= 16'd4) ? 3'd4 : rem_q[2:0];
  assign ecc       = dsi_ecc({wc_q, di_q});

  // Chained per-byte updates so the tail CRC can merge into the last payload word
  assign crc_b1 = crc_byte(crc_q,  pld_data[7:0]);
  assign crc_b2 = crc_byte(crc_b1, pld_data[15:8]);
  assign crc_b3 = crc_byte(crc_b2, pld_data[23:16]);
  assign crc_b4 = crc_byte(crc_b3, pld_data[31:24]);

  always_comb begin
    case (k)
      3'd1:    crc_upd = crc_b1;
      3'd2:    crc_upd = crc_b2;
      3'd3:    crc_upd = crc_b3;
      default: crc_upd = crc_b4;
    endcase
  end

  assign crc_tx   = CRC_ENABLE ? crc_upd : '0;
  assign crc_hold = CRC_ENABLE ? crc_q   : '0;

  always_comb begin
    state_d   = state_q;
    di_d      = di_q;
    wc_d      = wc_q;
    long_d    = long_q;
    rem_d     = rem_q;
    crc_d     = crc_q;
    data_d    = data_q;
    strb_d    = strb_q;
    last_d    = last_q;
    rqst_d    = rqst_q && !iface_data_rqst;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pld_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pkt_rqst) begin
          di_d    = pkt_data_id;
          wc_d    = pkt_word_count;
          long_d  = pkt_long;
          rem_d   = pkt_word_count;
          crc_d   = 16'hFFFF;
          busy_d  = 1'b1;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (slot_free) begin
          data_d  = {2'b00, ecc, wc_q, di_q};
          strb_d  = 4'hf;
          rqst_d  = 1'b1;
          last_d  = !long_q;
          if (!long_q)          state_d = S_LAST;
          else if (wc_q == '0)  state_d = S_CRC;
          else                  state_d = S_PLD;
        end
      end
      S_PLD: begin
        pld_ready = slot_free;
        if (slot_free && pld_valid) begin
          rqst_d = 1'b1;
          crc_d  = crc_upd;
          rem_d  = rem_q - {13'd0, k};
          strb_d = 4'hf;
          last_d = 1'b0;
          case (k)
            3'd1: begin
              data_d  = {8'h00, crc_tx, pld_data[7:0]};
              strb_d  = 4'h7;
              last_d  = 1'b1;
              state_d = S_LAST;
            end
            3'd2: begin
              data_d  = {crc_tx, pld_data[15:0]};
              last_d  = 1'b1;
              state_d = S_LAST;
            end
            3'd3: begin
              data_d  = {crc_tx[7:0], pld_data[23:0]};
              state_d = S_CRC;
            end
            default: begin
              data_d = pld_data;
              if (rem_q == 16'd4) state_d = S_CRC;
            end
          endcase
        end
      end
      S_CRC: begin
        if (slot_free) begin
          rqst_d  = 1'b1;
          last_d  = 1'b1;
          state_d = S_LAST;
          // WC mod 4 == 3 means CRClo already rode in the last payload word
          if (wc_q[1:0] == 2'd3) begin
            data_d = {24'h0, crc_hold[15:8]};
            strb_d = 4'h1;
          end else begin
            data_d = {16'h0, crc_hold};
            strb_d = 4'h3;
          end
        end
      end
      S_LAST: begin
        if (rqst_q && iface_data_rqst) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      di_q    <= '0;
      wc_q    <= '0;
      long_q  <= 1'b0;
      rem_q   <= '0;
      crc_q   <= '1;
      data_q  <= '0;
      strb_q  <= '0;
      rqst_q  <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      di_q    <= di_d;
      wc_q    <= wc_d;
      long_q  <= long_d;
      rem_q   <= rem_d;
      crc_q   <= crc_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      rqst_q  <= rqst_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign iface_write_data = data_q;
  assign iface_write_strb = strb_q;
  assign iface_write_rqst = rqst_q;
  assign iface_last_word  = last_q;
  assign pkt_busy         = busy_q;
  assign pkt_done         = done_q;

endmodule
